// File: rtl/vga_gen.sv
// vga_gen: VGA timing generator with registered sync, data-enable,
// coordinates and a selectable test pattern (gradient, bars, checker, black).
// Optional build macro: VGA_BORDER_EN adds a one-pixel all-ones frame border.
module vga_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CW       = 5,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic          clk_25,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [10:0]   x,
    output logic [10:0]   y,
    output logic          frame_start
);

    localparam int unsigned CNT_W    = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAND1    = H_ACTIVE / 3;
    localparam int unsigned BAND2    = (2 * H_ACTIVE) / 3;
    localparam int unsigned BAR_W    = ((H_ACTIVE / 8) == 0) ? 1 : (H_ACTIVE / 8);

    localparam logic [1:0] MODE_GRAD  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]       active_mode_q, active_mode_d;
    logic [CW-1:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             de_q, de_d, frame_start_q, frame_start_d;
    logic [10:0]      x_q, x_d, y_q, y_d;

    logic             h_last, v_last, visible;
    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar;
    logic [CW-1:0]    ones, intensity;
`ifdef VGA_BORDER_EN
    logic             border;
`endif

    // Next counter state, pattern colour and sync levels from the current counters
    always_comb begin
        h_cnt_d       = h_cnt_q + CNT_W'(1);
        v_cnt_d       = v_cnt_q;
        active_mode_d = active_mode_q;
        red_d         = '0;
        green_d       = '0;
        blue_d        = '0;
        ones          = {CW{1'b1}};
        intensity     = CW'(v_cnt_q >> 4);
        bar_idx       = h_cnt_q / CNT_W'(BAR_W);
        bar           = (bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0];

        h_last  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_last  = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        visible = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));

        if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : (v_cnt_q + CNT_W'(1));
            if (v_last) begin
                active_mode_d = mode;
            end
        end

        if (visible) begin
            case (active_mode_q)
                MODE_GRAD: begin
                    if (h_cnt_q < CNT_W'(BAND1)) begin
                        red_d = intensity;
                    end else if (h_cnt_q < CNT_W'(BAND2)) begin
                        green_d = intensity;
                    end else begin
                        blue_d = intensity;
                    end
                end
                MODE_BARS: begin
                    red_d   = bar[2] ? '0 : ones;
                    green_d = bar[1] ? '0 : ones;
                    blue_d  = bar[0] ? '0 : ones;
                end
                MODE_CHECK: begin
                    if ((h_cnt_q[5] ^ v_cnt_q[5]) == 1'b0) begin
                        red_d   = ones;
                        green_d = ones;
                        blue_d  = ones;
                    end
                end
                default: begin
                    red_d   = '0;
                    green_d = '0;
                    blue_d  = '0;
                end
            endcase
`ifdef VGA_BORDER_EN
            border = (h_cnt_q == '0) || (h_cnt_q == CNT_W'(H_ACTIVE - 1)) ||
                     (v_cnt_q == '0) || (v_cnt_q == CNT_W'(V_ACTIVE - 1));
            if (border) begin
                red_d   = ones;
                green_d = ones;
                blue_d  = ones;
            end
        end else begin
            border = 1'b0;
`endif
        end

        hsync_d = ((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END))) ? HS_POL : ~HS_POL;
        vsync_d = ((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END))) ? VS_POL : ~VS_POL;
        de_d          = visible;
        x_d           = 11'(h_cnt_q);
        y_d           = 11'(v_cnt_q);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Counter, mode and output registers; outputs lag the counters by one clock
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            active_mode_q <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            active_mode_q <= active_mode_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_gen.sv
// tb_vga_gen: directed plus randomized-mode bench for vga_gen, using a reduced
// raster and an arithmetic pixel model. Honours VGA_BORDER_EN if defined.
module tb_vga_gen;

    localparam int HA  = 96;
    localparam int HFP = 4;
    localparam int HSW = 8;
    localparam int HBP = 6;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSW = 3;
    localparam int VBP = 3;
    localparam int CW  = 5;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int VW  = 3 * CW + 26;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;

    logic          clk_25;
    logic          rst_n;
    logic [1:0]    mode;
    logic [CW-1:0] red, green, blue;
    logic          hsync, vsync, de, frame_start;
    logic [10:0]   x, y;

    vga_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CW(CW), .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk_25(clk_25), .rst_n(rst_n), .mode(mode),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .frame_start(frame_start)
    );

    initial clk_25 = 1'b0;
    always #5 clk_25 = ~clk_25;

    wire [VW-1:0] got_v = {red, green, blue, hsync, vsync, de, x, y, frame_start};

    int errors = 0;
    int checks = 0;
    int mh, mv, oh, ov;
    logic [1:0] mmode;

    // Expected registered outputs for raster position (h,v) under pattern m
    function automatic logic [VW-1:0] model(input int h, input int v, input logic [1:0] m);
        logic [CW-1:0] r, g, b, all1;
        logic de_e, hs_e, vs_e;
        int bar, inten;
        all1 = '1;
        r = '0; g = '0; b = '0;
        de_e = (h < HA) && (v < VA);
        hs_e = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : !HS_POL;
        vs_e = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : !VS_POL;
        if (de_e) begin
            case (m)
                2'd0: begin
                    inten = (v / 16) % 32;
                    if (h < HA / 3)          r = CW'(inten);
                    else if (h < 2 * HA / 3) g = CW'(inten);
                    else                     b = CW'(inten);
                end
                2'd1: begin
                    bar = h / (HA / 8);
                    if (bar > 7) bar = 7;
                    r = (bar < 4) ? all1 : '0;
                    g = (((bar / 2) % 2) == 0) ? all1 : '0;
                    b = ((bar % 2) == 0) ? all1 : '0;
                end
                2'd2: begin
                    if (((h / 32) % 2) == ((v / 32) % 2)) begin
                        r = all1; g = all1; b = all1;
                    end
                end
                default: ;
            endcase
`ifdef VGA_BORDER_EN
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
                r = all1; g = all1; b = all1;
            end
`endif
        end
        return {r, g, b, hs_e, vs_e, de_e, 11'(h), 11'(v), (h == 0 && v == 0)};
    endfunction

    function automatic logic [VW-1:0] reset_vec();
        return {CW'(0), CW'(0), CW'(0), !HS_POL, !VS_POL, 1'b0, 11'd0, 11'd0, 1'b0};
    endfunction

    task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h (x=%0d y=%0d)", tag, obs, exp, oh, ov);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        mh = 0; mv = 0; mmode = 2'd0; oh = -1; ov = -1;
    endtask

    // One clock: predict outputs from the model raster, advance it, compare
    task automatic tick();
        logic [VW-1:0] e;
        @(posedge clk_25);
        e  = model(mh, mv, mmode);
        oh = mh;
        ov = mv;
        if (mh == HT - 1 && mv == VT - 1) mmode = mode;
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        #1;
        check_vec("pixel", got_v, e);
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(oh == h && ov == v) && n < HT * VT + 4) begin
            tick();
            n++;
        end
        check_int("reach_pixel", (oh == h && ov == v) ? 1 : 0, 1);
    endtask

    task automatic check_rgb(input string tag, input int r, input int g, input int b);
        check_int(tag, int'({red, green, blue}), int'({CW'(r), CW'(g), CW'(b)}));
    endtask

    initial begin
        int hs_tot, vs_tot, de_tot, de_l0, blank_bad, first_hs;
        int border_exp;
        rst_n = 1'b1;
        mode  = 2'd0;
        reset_model();
`ifdef VGA_BORDER_EN
        border_exp = 31;
`else
        border_exp = 0;
`endif

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_vec("reset_async", got_v, reset_vec());
        repeat (3) @(posedge clk_25);
        #1 check_vec("reset_hold", got_v, reset_vec());
        @(negedge clk_25) rst_n = 1'b1;
        tick();
        check_int("first_frame_start", int'(frame_start), 1);
        check_int("first_xy", int'({x, y}), 0);

        // Full-frame timing statistics (gradient mode)
        hs_tot = 0; vs_tot = 0; de_tot = 0; de_l0 = 0; blank_bad = 0; first_hs = -1;
        for (int n = 0; n < HT * VT; n++) begin
            if (n > 0) tick();
            if (hsync == HS_POL) begin
                hs_tot++;
                if (ov == 0 && first_hs < 0) first_hs = int'(x);
            end
            if (vsync == VS_POL) vs_tot++;
            if (de) de_tot++;
            if (de && ov == 0) de_l0++;
            if (!de && (red != 0 || green != 0 || blue != 0)) blank_bad++;
        end
        check_int("hsync_cycles", hs_tot, HSW * VT);
        check_int("hsync_first_x", first_hs, HA + HFP);
        check_int("vsync_cycles", vs_tot, VSW * HT);
        check_int("de_cycles", de_tot, HA * VA);
        check_int("de_line0", de_l0, HA);
        check_int("blank_colour", blank_bad, 0);

        // Mid-frame mode change waits for the next frame
        run_to(20, 20);
        mode = 2'd1;
        run_to(30, 20);
        check_rgb("grad_after_change", 1, 0, 0);
        run_to(0, 0);
        check_int("fs_new_frame", int'(frame_start), 1);
        check_rgb("bar0_white", 31, 31, 31);
        run_to(80, 1);
        check_rgb("bar6_blue", 0, 0, 31);
        run_to(90, 1);
        check_rgb("bar7_black", 0, 0, 0);

        // Gradient spot checks
        mode = 2'd0;
        run_to(0, 0);
        run_to(40, 32);
        check_rgb("grad_green", 0, 2, 0);
        run_to(70, 33);
        check_rgb("grad_blue", 0, 0, 2);

        // Checkerboard spot checks
        mode = 2'd2;
        run_to(0, 0);
        run_to(10, 5);
        check_rgb("check_on", 31, 31, 31);
        run_to(32, 6);
        check_rgb("check_off", 0, 0, 0);

        // Black mode and optional border
        mode = 2'd3;
        run_to(0, 0);
        run_to(0, 5);
        check_rgb("left_edge", border_exp, border_exp, border_exp);
        run_to(5, 5);
        check_rgb("interior", 0, 0, 0);
        run_to(HA - 1, 5);
        check_rgb("right_edge", border_exp, border_exp, border_exp);
        run_to(5, VA - 1);
        check_rgb("bottom_edge", border_exp, border_exp, border_exp);

        // Randomized mode changes across two frames
        for (int n = 0; n < 2 * HT * VT; n++) begin
            tick();
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
        end

        // Mid-frame reset abandons the frame
        mode = 2'($urandom_range(0, 3));
        run_to(50, 30);
        #2 rst_n = 1'b0;
        #1 check_vec("reset_mid", got_v, reset_vec());
        repeat (2) @(posedge clk_25);
        #1 check_vec("reset_mid_hold", got_v, reset_vec());
        @(negedge clk_25) rst_n = 1'b1;
        reset_model();
        tick();
        check_int("restart_frame_start", int'(frame_start), 1);
        check_int("restart_xy", int'({x, y}), 0);
        repeat (300) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
